// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Accumulates unsigned 2N-bit products from the upstream multiplier into a
// wide saturating accumulator. A beat tagged with in_last closes the block:
// the finished sum, beat count and overflow flag are loaded into registered
// outputs and held behind an out_valid/out_ready handshake.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   clear      - synchronous clear of the accumulation in progress (ACCUM only)
//   in_valid   - product beat valid
//   in_ready   - block can accept a beat (ACCUM state and not in reset)
//   product    - unsigned 2N-bit product
//   in_last    - marks the final beat of a block
//   out_valid  - result valid
//   out_ready  - downstream accepts the result
//   acc_out    - saturated block sum
//   count_out  - saturated beat count of the block
//   overflow   - the block sum saturated
// -----------------------------------------------------------------------------
module product_accumulator #(
  parameter int N     = 16,
  parameter int ACC_W = 2*N + 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] count_out,
  output logic             overflow
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]       state_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic [ACC_W-1:0] acc_out_r;
  logic [CNT_W-1:0] count_out_r;
  logic             overflow_r;

  logic [ACC_W:0]   sum_s;
  logic [ACC_W-1:0] acc_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             ovf_nxt_s;
  logic             accept_s;

  // Ready depends on state only; held low while reset is asserted.
  assign in_ready  = (state_r == ACCUM) && !rst;
  assign out_valid = out_valid_r;
  assign acc_out   = acc_out_r;
  assign count_out = count_out_r;
  assign overflow  = overflow_r;

  // Next accumulator values for an accepted beat: saturating add and count.
  always_comb begin
    accept_s  = in_valid && in_ready;
    sum_s     = {1'b0, acc_r} + {{(ACC_W+1-2*N){1'b0}}, product};
    acc_nxt_s = sum_s[ACC_W-1:0];
    ovf_nxt_s = 1'b0;
    cnt_nxt_s = cnt_r;
    // Once saturated, the block stays pinned at all-ones.
    if (sum_s[ACC_W] || ovf_r) begin
      acc_nxt_s = {ACC_W{1'b1}};
      ovf_nxt_s = 1'b1;
    end else begin
      acc_nxt_s = sum_s[ACC_W-1:0];
      ovf_nxt_s = 1'b0;
    end
    if (cnt_r == {CNT_W{1'b1}}) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Block state machine, accumulator and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ACCUM;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      acc_out_r   <= {ACC_W{1'b0}};
      count_out_r <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          // clear wins over a coincident beat, including its in_last.
          if (clear) begin
            acc_r <= {ACC_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            ovf_r <= 1'b0;
          end else if (accept_s) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_nxt_s;
            ovf_r <= ovf_nxt_s;
            if (in_last) begin
              acc_out_r   <= acc_nxt_s;
              count_out_r <= cnt_nxt_s;
              overflow_r  <= ovf_nxt_s;
              out_valid_r <= 1'b1;
              state_r     <= HOLD;
            end else begin
              state_r     <= ACCUM;
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        HOLD: begin
          // Result outputs keep their values; only the working state resets.
          if (out_ready) begin
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            state_r     <= ACCUM;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r     <= ACCUM;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//
// Directed and randomized checks of product_accumulator. A default-sized
// instance (N=16) covers the normal path, holding, clear and reset; a small
// instance (N=4, ACC_W=10) covers saturation. Expected block results come
// from a queue of accepted products summed with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance
  logic        clear, in_valid, in_last, out_ready;
  logic [31:0] product;
  logic        in_ready, out_valid, overflow;
  logic [39:0] acc_out;
  logic [7:0]  count_out;

  // Small instance for saturation
  logic        s_clear, s_in_valid, s_in_last, s_out_ready;
  logic [7:0]  s_product;
  logic        s_in_ready, s_out_valid, s_overflow;
  logic [9:0]  s_acc_out;
  logic [7:0]  s_count_out;

  int n_checks = 0;
  int n_fail   = 0;

  longint blk_q[$];
  longint exp_acc_q[$];
  int     exp_cnt_q[$];
  bit     exp_ovf_q[$];

  product_accumulator dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .count_out(count_out), .overflow(overflow)
  );

  product_accumulator #(.N(4), .ACC_W(10), .CNT_W(8)) dut_small (
    .clk(clk), .rst(rst), .clear(s_clear), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .product(s_product), .in_last(s_in_last), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .acc_out(s_acc_out), .count_out(s_count_out), .overflow(s_overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: saturated sum, overflow flag and saturated count of a block.
  task automatic ref_block(input int accw, output longint acc, output bit ovf, output int cnt);
    longint s;
    longint mx;
    s  = 0;
    mx = (longint'(1) << accw) - 1;
    foreach (blk_q[i]) s += blk_q[i];
    ovf = (s > mx);
    acc = ovf ? mx : s;
    cnt = (blk_q.size() > 255) ? 255 : blk_q.size();
    blk_q.delete();
  endtask

  task automatic beat(input logic [31:0] p, input bit last);
    in_valid = 1'b1; product = p; in_last = last;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic sbeat(input logic [7:0] p, input bit last);
    s_in_valid = 1'b1; s_product = p; s_in_last = last;
    blk_q.push_back(longint'(p));
    @(negedge clk);
    s_in_valid = 1'b0; s_in_last = 1'b0;
  endtask

  task automatic result(input string tag, input longint a, input int c, input bit o);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_acc"}, acc_out, a);
    check({tag, "_cnt"}, count_out, c);
    check({tag, "_ovf"}, overflow, o);
    check({tag, "_inrdy"}, in_ready, 0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_hs_inrdy"}, in_ready, 1);
    check({tag, "_hs_valid"}, out_valid, 0);
  endtask

  initial begin
    longint ea;
    bit     eo;
    int     ec;
    logic [31:0] a, b;
    int sent, got, cyc;

    clear = 0; in_valid = 0; in_last = 0; out_ready = 0; product = '0;
    s_clear = 0; s_in_valid = 0; s_in_last = 0; s_out_ready = 0; s_product = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_inrdy", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_acc", acc_out, 0);
    check("rst_cnt", count_out, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    #1 check("rel_inrdy", in_ready, 1);
    @(negedge clk);

    // Basic block 6,10,4
    beat(6, 0);
    beat(10, 0);
    check("basic_notyet", out_valid, 0);
    beat(4, 1);
    result("basic", 20, 3, 0);
    handshake("basic");

    // Full-scale beat held for 5 cycles; a beat offered during HOLD is ignored
    beat(32'hFFFE0001, 1);
    in_valid = 1'b1; product = 32'd7;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_acc", acc_out, 64'hFFFE0001);
      check("hold_inrdy", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check("hold_hs_inrdy", in_ready, 1);
    check("hold_hs_valid", out_valid, 0);
    check("hold_cnt", count_out, 1);

    // Saturation on small instance
    for (int i = 0; i < 4; i++) sbeat(225, 0);
    sbeat(225, 1);
    ref_block(10, ea, eo, ec);
    check("sat_valid", s_out_valid, 1);
    check("sat_acc", s_acc_out, ea);
    check("sat_acc_const", s_acc_out, 1023);
    check("sat_ovf", s_overflow, eo);
    check("sat_cnt", s_count_out, ec);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    sbeat(1, 0);
    sbeat(2, 1);
    ref_block(10, ea, eo, ec);
    check("sat2_acc", s_acc_out, ea);
    check("sat2_ovf", s_overflow, 0);
    check("sat2_cnt", s_count_out, 2);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;

    // Clear wins over a coincident last beat; clear in HOLD is ignored
    beat(7, 0);
    beat(9, 0);
    clear = 1'b1; in_valid = 1'b1; product = 32'd5; in_last = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("clr_novalid", out_valid, 0);
    check("clr_inrdy", in_ready, 1);
    beat(3, 1);
    result("clr", 3, 1, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    result("clr_hold", 3, 1, 0);
    handshake("clr");

    // Reset mid-block, then reset during HOLD
    beat(100, 0);
    beat(200, 0);
    rst = 1'b1;
    #1 check("midrst_inrdy", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    beat(50, 1);
    result("midrst", 50, 1, 0);
    rst = 1'b1;
    #1;
    check("holdrst_valid", out_valid, 0);
    check("holdrst_acc", acc_out, 0);
    check("holdrst_cnt", count_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random back-to-back: 40 products a*b, last every 8th accepted beat
    sent = 0; got = 0; cyc = 0;
    while ((sent < 40 || got < 5) && cyc < 3000) begin
      if (out_valid) begin
        if (exp_acc_q.size() == 0) begin
          check("rnd_unexpected", out_valid, 0);
        end else begin
          check("rnd_acc", acc_out, exp_acc_q[0]);
          check("rnd_cnt", count_out, exp_cnt_q[0]);
          check("rnd_ovf", overflow, exp_ovf_q[0]);
        end
      end
      check("rnd_inrdy", in_ready, !out_valid);
      out_ready = ($urandom_range(0, 1) == 1);
      if (out_valid && out_ready && exp_acc_q.size() > 0) begin
        void'(exp_acc_q.pop_front());
        void'(exp_cnt_q.pop_front());
        void'(exp_ovf_q.pop_front());
        got++;
      end
      a = $urandom_range(0, 65535);
      b = $urandom_range(0, 65535);
      product  = a * b;
      in_last  = ((sent + 1) % 8 == 0);
      in_valid = (sent < 40) && ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        blk_q.push_back(longint'(product));
        sent++;
        if (in_last) begin
          ref_block(40, ea, eo, ec);
          exp_acc_q.push_back(ea);
          exp_cnt_q.push_back(ec);
          exp_ovf_q.push_back(eo);
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    check("rnd_results", got, 5);
    check("rnd_sent", sent, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulator that sits directly downstream of the N-bit combinational multiplier (built from 4-bit partial multipliers). It takes one unsigned 2N-bit product per handshake and adds it into a wide accumulator. When a beat is tagged as last, it presents the finished sum and beat count on a registered output with its own handshake. Together with the multiplier it forms the dot-product/MAC path.

## Interface
- N, default 16: operand width of the upstream multiplier; product width is 2N.
- ACC_W, default 2N+8: accumulator width; must be ≥ 2N+1.
- CNT_W, default 8: beat-counter width.
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- clear  in  1: synchronous clear of the accumulation in progress.
- in_valid  in  1: product beat valid.
- in_ready  out  1: block can accept a beat.
- product  in  2N: unsigned product from the multiplier.
- in_last  in  1: qualifies the current beat as the final beat of a block.
- out_valid  out  1: result valid.
- out_ready  in  1: downstream accepts the result.
- acc_out  out  ACC_W: accumulated sum, saturated.
- count_out  out  CNT_W: number of beats in the block, saturated.
- overflow  out  1: sticky flag; the sum saturated in this block.

## Operation
- States: ACCUM, HOLD. Reset state is ACCUM.
- Internal registers: acc (ACC_W), cnt (CNT_W), ovf (1).
- in_ready = (state == ACCUM) && !rst. It is combinational from state only and does not depend on in_valid.
- Beat accepted when in_valid && in_ready.
- On an accepted beat in ACCUM:
  - sum = acc + zero-extended product, computed at ACC_W+1 bits.
  - If sum[ACC_W] is set or ovf is already set: acc becomes all-ones and ovf is set.
  - Otherwise acc = sum[ACC_W-1:0].
  - cnt increments and saturates at 2^CNT_W−1.
- If the accepted beat has in_last=1: the updated acc, cnt and ovf are loaded into acc_out, count_out and overflow, and the state moves to HOLD.
- HOLD:
  - out_valid=1 and in_ready=0.
  - On out_ready=1: acc, cnt and ovf clear to 0 and the state returns to ACCUM.
  - acc_out, count_out and overflow stay stable until the next result is loaded.
- clear in ACCUM: acc, cnt and ovf go to 0. If a beat is accepted in the same cycle, clear wins and the beat is discarded, including its in_last.
- clear in HOLD: ignored.
- Zero-length blocks cannot occur; every block ends on an accepted beat.
- Arithmetic is unsigned only. Product bits above 2N are never driven, and no sign handling is applied.

## Timing
- Reset values: state=ACCUM, acc/cnt/ovf=0, out_valid=0, acc_out=0, count_out=0, overflow=0. in_ready=0 while rst is high and 1 in the first cycle after release.
- Throughput: one beat per cycle while in ACCUM.
- Latency: out_valid rises on the clock edge that accepts the in_last beat, so it is visible in the following cycle.
- Result handshake completes on an edge where out_valid && out_ready. in_ready is 1 in the next cycle, giving exactly one bubble cycle per block.
- out_valid deasserts only on result handshake or rst.
- rst asserted mid-block or in HOLD: all state clears immediately (asynchronously); the partial sum and any pending result are lost.
- out_ready asserted while in ACCUM: no effect.

## Test plan
- After reset release, the beats 6, 10, 4 (last on 4) with N=16 → out_valid the cycle after the third beat; acc_out=20, count_out=3, overflow=0.
- Full-scale beat: product 0xFFFE0001 with in_last, then hold out_ready=0 for 5 cycles → out_valid stays 1 and acc_out=0xFFFE0001 stays stable; in_ready=0 throughout; after out_ready=1, in_ready=1 one cycle later.
- Saturation with N=4, ACC_W=10: five beats of 225 → acc_out=1023, overflow=1, count_out=5. The next block of 1, 2 → acc_out=3, overflow=0.
- Clear: beats 7, 9, then clear coinciding with a beat of 5 (last), then beat 3 (last) → acc_out=3, count_out=1.
- Reset mid-block: beats 100, 200, rst pulse, then beat 50 (last) → acc_out=50, count_out=1. rst asserted during HOLD → out_valid drops asynchronously to 0.
- Back-to-back: 40 beats with random in_valid gaps, chained to the multiplier with random 16-bit a/b and a last every 8th beat → each result equals the reference sum of a·b for its block, with zero mismatches.
